pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register; next generation of the fixed-field MEM/WB register.
- Carries a control field, cleared on reset, flush and bubbles, plus a data field. Both are configurable in width.
- Adds valid/ready flow control, synchronous flush and an optional 2-entry skid buffer, so any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can stall without a combinational ready path.

---
 rtl/pipe_stage_skid.sv | 179 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Parametrised pipeline stage register with valid/ready flow
//               control, synchronous flush and an optional 2-entry skid
//               buffer. The control field is forced to zero whenever the
//               head entry is invalid. The data field holds its last value.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               flush          - synchronous discard of all held entries
//               in_valid/in_ready/in_ctrl/in_data     - upstream side
//               out_valid/out_ready/out_ctrl/out_data - downstream side
//               occupancy      - number of held entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_accept;
    logic              w_drain;

    // Main (head) entry registers; next values come from the mode-specific
    // control logic below.
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    // Bubbles never assert a control bit.
    assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_data = main_data_q;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_TWO   = 2'd2
            } state_t;

            state_t            state_q;
            state_t            state_d;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [CTRL_W-1:0] skid_ctrl_d;
            logic [DATA_W-1:0] skid_data_q;
            logic [DATA_W-1:0] skid_data_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= ST_EMPTY;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q     <= state_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    skid_data_q <= skid_data_d;
                end
            end

            always_comb begin
                state_d     = state_q;
                main_ctrl_d = main_ctrl_q;
                main_data_d = main_data_q;
                skid_ctrl_d = skid_ctrl_q;
                skid_data_d = skid_data_q;
                if (flush) begin
                    // Data registers are intentionally left untouched.
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                state_d     = ST_ONE;
                                main_ctrl_d = in_ctrl;
                                main_data_d = in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_drain) begin
                                main_ctrl_d = in_ctrl;
                                main_data_d = in_data;
                            end else if (w_accept) begin
                                state_d     = ST_TWO;
                                skid_ctrl_d = in_ctrl;
                                skid_data_d = in_data;
                            end else if (w_drain) begin
                                state_d     = ST_EMPTY;
                                main_ctrl_d = '0;
                            end
                        end
                        ST_TWO: begin
                            // in_ready is low here, so only a drain can occur.
                            if (w_drain) begin
                                state_d     = ST_ONE;
                                main_ctrl_d = skid_ctrl_q;
                                main_data_d = skid_data_q;
                                skid_ctrl_d = '0;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                        end
                    endcase
                end
            end

            // Depends on state only: no combinational path from out_ready.
            assign in_ready  = (state_q != ST_TWO);
            assign out_valid = (state_q != ST_EMPTY);
            assign occupancy = (state_q == ST_TWO) ? 2'd2 :
                               (state_q == ST_ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            logic valid_q;
            logic valid_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            always_comb begin
                valid_d     = valid_q;
                main_ctrl_d = main_ctrl_q;
                main_data_d = main_data_q;
                if (flush) begin
                    valid_d     = 1'b0;
                    main_ctrl_d = '0;
                end else if (w_accept) begin
                    // Covers simultaneous drain: the register simply reloads.
                    valid_d     = 1'b1;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (w_drain) begin
                    valid_d     = 1'b0;
                    main_ctrl_d = '0;
                end
            end

            assign in_ready  = ~valid_q | out_ready;
            assign out_valid = valid_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. One instance with
//               the skid buffer and one without share the same stimulus; each
//               is compared against a FIFO-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int CW = 2;
    localparam int DW = 69;
    localparam int EW = CW + DW;

    logic          clk = 1'b0;
    logic          r_rst_n;
    logic          r_flush;
    logic          r_in_valid;
    logic [CW-1:0] r_in_ctrl;
    logic [DW-1:0] r_in_data;
    logic          r_out_ready;

    logic          w_s1_in_ready, w_s1_out_valid;
    logic [CW-1:0] w_s1_out_ctrl;
    logic [DW-1:0] w_s1_out_data;
    logic [1:0]    w_s1_occ;
    logic          w_s0_in_ready, w_s0_out_valid;
    logic [CW-1:0] w_s0_out_ctrl;
    logic [DW-1:0] w_s0_out_data;
    logic [1:0]    w_s0_occ;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut_skid (
        .clk(clk), .rst_n(r_rst_n), .flush(r_flush),
        .in_valid(r_in_valid), .in_ready(w_s1_in_ready),
        .in_ctrl(r_in_ctrl), .in_data(r_in_data),
        .out_valid(w_s1_out_valid), .out_ready(r_out_ready),
        .out_ctrl(w_s1_out_ctrl), .out_data(w_s1_out_data),
        .occupancy(w_s1_occ)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut_single (
        .clk(clk), .rst_n(r_rst_n), .flush(r_flush),
        .in_valid(r_in_valid), .in_ready(w_s0_in_ready),
        .in_ctrl(r_in_ctrl), .in_data(r_in_data),
        .out_valid(w_s0_out_valid), .out_ready(r_out_ready),
        .out_ctrl(w_s0_out_ctrl), .out_data(w_s0_out_data),
        .occupancy(w_s0_occ)
    );

    // Reference model: ordered queue of {ctrl,data} entries plus the last
    // head data, which is what out_data shows while the stage is empty.
    logic [EW-1:0] m_q1[$];
    logic [EW-1:0] m_q0[$];
    logic [DW-1:0] m_last1;
    logic [DW-1:0] m_last0;

    int num_checks = 0;
    int num_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        num_checks++;
        if (got === exp) num_pass++;
        else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q1.delete();
        m_q0.delete();
        m_last1 = '0;
        m_last0 = '0;
    endtask

    task automatic check_outputs();
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        int            n1;
        int            n0;
        n1 = m_q1.size();
        n0 = m_q0.size();
        ec = (n1 > 0) ? m_q1[0][EW-1:DW] : '0;
        ed = (n1 > 0) ? m_q1[0][DW-1:0] : m_last1;
        chk("skid_in_ready",  128'(w_s1_in_ready),  128'(n1 < 2));
        chk("skid_out_valid", 128'(w_s1_out_valid), 128'(n1 > 0));
        chk("skid_out_ctrl",  128'(w_s1_out_ctrl),  128'(ec));
        chk("skid_out_data",  128'(w_s1_out_data),  128'(ed));
        chk("skid_occupancy", 128'(w_s1_occ),       128'(n1));
        ec = (n0 > 0) ? m_q0[0][EW-1:DW] : '0;
        ed = (n0 > 0) ? m_q0[0][DW-1:0] : m_last0;
        chk("single_in_ready",  128'(w_s0_in_ready),  128'((n0 == 0) || r_out_ready));
        chk("single_out_valid", 128'(w_s0_out_valid), 128'(n0 > 0));
        chk("single_out_ctrl",  128'(w_s0_out_ctrl),  128'(ec));
        chk("single_out_data",  128'(w_s0_out_data),  128'(ed));
        chk("single_occupancy", 128'(w_s0_occ),       128'(n0));
    endtask

    // Apply the handshake rules to the model using the pre-edge inputs.
    task automatic model_edge();
        bit acc1, dr1, acc0, dr0;
        acc1 = r_in_valid && (m_q1.size() < 2);
        dr1  = (m_q1.size() > 0) && r_out_ready;
        acc0 = r_in_valid && ((m_q0.size() == 0) || r_out_ready);
        dr0  = (m_q0.size() > 0) && r_out_ready;
        if (r_flush) begin
            m_q1.delete();
            m_q0.delete();
        end else begin
            if (dr1)  void'(m_q1.pop_front());
            if (acc1) m_q1.push_back({r_in_ctrl, r_in_data});
            if (dr0)  void'(m_q0.pop_front());
            if (acc0) m_q0.push_back({r_in_ctrl, r_in_data});
        end
        if (m_q1.size() > 0) m_last1 = m_q1[0][DW-1:0];
        if (m_q0.size() > 0) m_last0 = m_q0[0][DW-1:0];
    endtask

    // One clock cycle: drive inputs, check settled outputs, clock, update model.
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        r_in_valid  = v;
        r_in_ctrl   = c;
        r_in_data   = d;
        r_out_ready = ordy;
        r_flush     = fl;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [95:0] rnd;
        r_rst_n     = 1'b0;
        r_flush     = 1'b0;
        r_in_valid  = 1'b0;
        r_in_ctrl   = '0;
        r_in_data   = '0;
        r_out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out_valid", 128'(w_s1_out_valid), 128'(0));
        chk("reset_in_ready",  128'(w_s1_in_ready),  128'(1));
        chk("reset_out_data",  128'(w_s1_out_data),  128'(0));
        chk("reset_occupancy", 128'(w_s1_occ),       128'(0));
        r_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with no backpressure.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 2'b01, DW'(i), 1'b1, 1'b0);
        chk("stream_last_data", 128'(w_s1_out_data), 128'(5));
        chk("stream_occupancy", 128'(w_s1_occ),      128'(1));

        // Backpressure fills the skid buffer.
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
        cycle(1'b1, 2'b11, DW'('h11), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, DW'('h22), 1'b0, 1'b0);
        chk("bp_occupancy", 128'(w_s1_occ),      128'(2));
        chk("bp_in_ready",  128'(w_s1_in_ready), 128'(0));
        chk("bp_head_data", 128'(w_s1_out_data), 128'('h11));
        cycle(1'b0, 2'b00, '0, 1'b0, 1'b0);
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);

        // Flush with a full buffer while a new entry is offered.
        cycle(1'b1, 2'b11, DW'('h11), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, DW'('h22), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, DW'('h33), 1'b0, 1'b1);
        chk("flush_out_valid", 128'(w_s1_out_valid), 128'(0));
        chk("flush_out_ctrl",  128'(w_s1_out_ctrl),  128'(0));
        chk("flush_occupancy", 128'(w_s1_occ),       128'(0));
        repeat (2) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with the buffer full.
        cycle(1'b1, 2'b10, DW'('h44), 1'b0, 1'b0);
        cycle(1'b1, 2'b10, DW'('h55), 1'b0, 1'b0);
        #2;
        r_rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_out_valid", 128'(w_s1_out_valid), 128'(0));
        chk("areset_out_ctrl",  128'(w_s1_out_ctrl),  128'(0));
        chk("areset_out_data",  128'(w_s1_out_data),  128'(0));
        chk("areset_occupancy", 128'(w_s1_occ),       128'(0));
        check_outputs();
        r_rst_n = 1'b1;

        // Bubbles with control bits set on the input.
        repeat (3) begin
            cycle(1'b0, 2'b11, DW'($urandom()), 1'b1, 1'b0);
            chk("bubble_out_ctrl", 128'(w_s1_out_ctrl), 128'(0));
        end

        // Toggling out_ready under continuous input.
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'b01, DW'('h60 + i), (i % 2) == 0, 1'b0);
        repeat (3) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            cycle(($urandom() % 4) != 0, CW'($urandom()), rnd[DW-1:0],
                  ($urandom() % 3) != 0, ($urandom() % 25) == 0);
        end
        repeat (3) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
`default_nettype wire
